sha256_w_sched_seq: RTL and testbench

Sequential SHA-256 message-schedule generator feeding the compression-round stage. It accepts one 512-bit padded block over a valid/ready handshake. It then streams W[0]..W[NUM_WORDS-1], one word per accepted beat, from a 16-word sliding window. This is the iterative counterpart of the per-stage pipelined W-memory slices, reusing the same sigma0/sigma1 arithmetic.

---
 rtl/sha256_pkg.sv | 24 ++
 rtl/sha256_w_next.sv | 18 +
 rtl/sha256_w_sched_seq.sv | 113 +++++++++++
 tb/tb_sha256_w_sched_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word/block widths, the small sigma functions
// used by every message-schedule implementation, and the sequencer states.
package sha256_pkg;

  localparam int WORD_W    = 32;
  localparam int BLOCK_W   = 512;
  localparam int WIN_DEPTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } wsched_state_e;

  // sigma0: ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [WORD_W-1:0] sha256_s0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // sigma1: ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [WORD_W-1:0] sha256_s1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_w_next.sv
// Next message-schedule word: W[t+16] from W[t], W[t+1], W[t+9], W[t+14].
// Purely combinational so the pipelined W-memory stages can share it.
module sha256_w_next
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] w0_i,
  input  logic [WORD_W-1:0] w1_i,
  input  logic [WORD_W-1:0] w9_i,
  input  logic [WORD_W-1:0] w14_i,
  output logic [WORD_W-1:0] wNext_o
);

  // Modulo-2^32 sum of the four schedule terms
  always_comb begin
    wNext_o = sha256_s1(w14_i) + w9_i + sha256_s0(w1_i) + w0_i;
  end

endmodule

// File: rtl/sha256_w_sched_seq.sv
// Sequential SHA-256 message-schedule generator. Accepts one padded block,
// then streams W[0]..W[NUM_WORDS-1] out of a 16-word sliding window.
// Optional macro SHA256_WSCHED_B2B_EN lets a new block load during the
// last-word beat so consecutive blocks stream without an idle bubble.
module sha256_w_sched_seq
  import sha256_pkg::*;
#(
  parameter int NUM_WORDS = 64,
  parameter int IDX_W     = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [BLOCK_W-1:0] block_in,
  output logic               w_valid,
  input  logic               w_ready,
  output logic [WORD_W-1:0]  w_out,
  output logic [IDX_W-1:0]   w_idx,
  output logic               w_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  wsched_state_e     state_q, state_d;
  logic [WORD_W-1:0] win_q [WIN_DEPTH];
  logic [WORD_W-1:0] win_d [WIN_DEPTH];
  logic [IDX_W-1:0]  count_q, count_d;

  logic              isRun;
  logic              lastWord;
  logic              wordBeat;
  logic              loadBeat;
  logic              readyInt;
  logic [WORD_W-1:0] wNew;

  sha256_w_next uNext (
    .w0_i    (win_q[0]),
    .w1_i    (win_q[1]),
    .w9_i    (win_q[9]),
    .w14_i   (win_q[14]),
    .wNext_o (wNew)
  );

  // Handshake decode; blk_ready is held low whenever reset is asserted
  always_comb begin
    isRun    = (state_q == RUN);
    lastWord = (count_q == LAST_IDX);
    wordBeat = isRun && w_ready;
`ifdef SHA256_WSCHED_B2B_EN
    readyInt = !RST && ((state_q == IDLE) || (wordBeat && lastWord));
`else
    readyInt = !RST && (state_q == IDLE);
`endif
    loadBeat = blk_valid && readyInt;
  end

  // Next-state logic: a load takes priority over the final word beat so a
  // back-to-back block restarts the window without leaving RUN
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    count_d = count_q;
    if (loadBeat) begin
      for (int k = 0; k < WIN_DEPTH; k++) begin
        win_d[k] = block_in[BLOCK_W-1-WORD_W*k -: WORD_W];
      end
      count_d = '0;
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (wordBeat) begin
            if (lastWord) begin
              state_d = IDLE;
            end else begin
              for (int k = 0; k < WIN_DEPTH-1; k++) begin
                win_d[k] = win_q[k+1];
              end
              win_d[WIN_DEPTH-1] = wNew;
              count_d = count_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, window and word counter registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      win_q   <= '{default: '0};
      count_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      count_q <= count_d;
    end
  end

  // Output stream is always the head of the window
  always_comb begin
    blk_ready = readyInt;
    w_valid   = isRun;
    w_out     = win_q[0];
    w_idx     = count_q;
    w_last    = isRun && lastWord;
  end

endmodule

// File: tb/tb_sha256_w_sched_seq.sv
// Directed testbench for sha256_w_sched_seq: "abc" schedule, random stalls,
// back-to-back blocks, mid-block reset and a 16-word build.
module tb_sha256_w_sched_seq;

  logic         clock = 1'b0;
  logic         reset = 1'b1;

  logic         blkValid = 1'b0;
  logic         blkReady;
  logic [511:0] blockIn = '0;
  logic         wValid;
  logic         wReady = 1'b0;
  logic [31:0]  wOut;
  logic [5:0]   wIdx;
  logic         wLast;

  logic         blkValid16 = 1'b0;
  logic         blkReady16;
  logic [511:0] blockIn16 = '0;
  logic         wValid16;
  logic         wReady16 = 1'b0;
  logic [31:0]  wOut16;
  logic [3:0]   wIdx16;
  logic         wLast16;

  int           vecCount  = 0;
  int           missCount = 0;

  logic [31:0]  wExp [2][64];
  logic [511:0] blkA;
  logic [511:0] blkB;

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clock = ~clock;

  sha256_w_sched_seq #(.NUM_WORDS(64), .IDX_W(6)) dut (
    .CLK       (clock),
    .RST       (reset),
    .blk_valid (blkValid),
    .blk_ready (blkReady),
    .block_in  (blockIn),
    .w_valid   (wValid),
    .w_ready   (wReady),
    .w_out     (wOut),
    .w_idx     (wIdx),
    .w_last    (wLast)
  );

  sha256_w_sched_seq #(.NUM_WORDS(16), .IDX_W(4)) dut16 (
    .CLK       (clock),
    .RST       (reset),
    .blk_valid (blkValid16),
    .blk_ready (blkReady16),
    .block_in  (blockIn16),
    .w_valid   (wValid16),
    .w_ready   (wReady16),
    .w_out     (wOut16),
    .w_idx     (wIdx16),
    .w_last    (wLast16)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule from the textbook array recurrence
  task automatic buildSchedule(input int sel, input logic [511:0] b);
    logic [31:0] w [64];
    logic [31:0] sA, sB;
    for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      sA = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      sB = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = sB + w[t-7] + sA + w[t-16];
    end
    for (int t = 0; t < 64; t++) wExp[sel][t] = w[t];
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vecCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic bv, input logic [511:0] blk, input logic wr);
    blkValid = bv;
    blockIn  = blk;
    wReady   = wr;
  endtask

  // Offer a block (called just after a falling edge) until it is accepted;
  // returns at the falling edge after the load edge
  task automatic loadBlock(input logic [511:0] b, output bit ok);
    ok = 1'b0;
    blkValid = 1'b1;
    blockIn  = b;
    for (int i = 0; i < 300 && !ok; i++) begin
      #1;
      if (blkReady) ok = 1'b1;
      @(negedge clock);
    end
    blkValid = 1'b0;
  endtask

  // Directed sequence
  initial begin
    bit ok;
    bit seenLast;
    bit done;
    int gap;
    int beats;
    int expIdx;
    int expGap;

`ifdef SHA256_WSCHED_B2B_EN
    expGap = 0;
`else
    expGap = 1;
`endif

    blkA = '0;
    blkA[511:480] = 32'h61626380;
    blkA[31:0]    = 32'h00000018;
    for (int k = 0; k < 16; k++) blkB[511-32*k -: 32] = 32'h9e3779b9 * (k + 1);
    buildSchedule(0, blkA);
    buildSchedule(1, blkB);

    // Reset state
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    checkOutput("rst_valid", 64'(wValid), 64'd0);
    checkOutput("rst_out", 64'(wOut), 64'd0);
    checkOutput("rst_idx", 64'(wIdx), 64'd0);
    checkOutput("rst_last", 64'(wLast), 64'd0);
    checkOutput("rst_ready_forced", 64'(blkReady), 64'd0);
    checkOutput("rst16_valid", 64'(wValid16), 64'd0);
    reset = 1'b0;
    #1 checkOutput("idle_ready", 64'(blkReady), 64'd1);

    // Test 1: "abc" block at full rate
    applyStimulus(1'b0, blkA, 1'b1);
    loadBlock(blkA, ok);
    checkOutput("t1_load", 64'(ok), 64'd1);
    for (int t = 0; t < 64; t++) begin
      checkOutput($sformatf("t1_valid%0d", t), 64'(wValid), 64'd1);
      checkOutput($sformatf("t1_idx%0d", t), 64'(wIdx), 64'(t));
      checkOutput($sformatf("t1_w%0d", t), 64'(wOut), 64'(wExp[0][t]));
      checkOutput($sformatf("t1_last%0d", t), 64'(wLast), 64'(t == 63));
      if (t == 16) checkOutput("t1_W16", 64'(wOut), 64'h61626380);
      if (t == 17) checkOutput("t1_W17", 64'(wOut), 64'h000f0000);
      if (t == 18) checkOutput("t1_W18", 64'(wOut), 64'h7da86405);
      if (t == 19) checkOutput("t1_W19", 64'(wOut), 64'h600003c6);
      if (t == 63) checkOutput("t1_W63", 64'(wOut), 64'h12b1edeb);
      @(negedge clock);
    end
    checkOutput("t1_idle_valid", 64'(wValid), 64'd0);

    // Test 2: same block with random back-pressure
    applyStimulus(1'b0, blkA, 1'b0);
    loadBlock(blkA, ok);
    checkOutput("t2_load", 64'(ok), 64'd1);
    expIdx = 0;
    beats  = 0;
    for (int c = 0; c < 2000 && expIdx < 64; c++) begin
      checkOutput("t2_valid", 64'(wValid), 64'd1);
      checkOutput("t2_idx", 64'(wIdx), 64'(expIdx));
      checkOutput("t2_w", 64'(wOut), 64'(wExp[0][expIdx]));
      checkOutput("t2_last", 64'(wLast), 64'(expIdx == 63));
      wReady = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clock);
      if (wReady) begin
        beats++;
        expIdx++;
      end
    end
    checkOutput("t2_beats", 64'(beats), 64'd64);
    checkOutput("t2_idle_valid", 64'(wValid), 64'd0);

    // Test 3 and 6: block B offered continuously while block A streams
    applyStimulus(1'b1, blkA, 1'b1);
    #1 checkOutput("t3_ready_idle", 64'(blkReady), 64'd1);
    @(negedge clock);
    blockIn  = blkB;
    seenLast = 1'b0;
    done     = 1'b0;
    gap      = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (wValid && !seenLast) begin
        checkOutput($sformatf("t3_idx%0d", c), 64'(wIdx), 64'(c));
        checkOutput($sformatf("t3_w%0d", c), 64'(wOut), 64'(wExp[0][c]));
`ifdef SHA256_WSCHED_B2B_EN
        checkOutput($sformatf("t3_ready%0d", c), 64'(blkReady), 64'(wLast));
`else
        checkOutput($sformatf("t3_ready%0d", c), 64'(blkReady), 64'd0);
`endif
        if (wLast) seenLast = 1'b1;
      end else if (wValid && seenLast) begin
        checkOutput("t3_b_idx0", 64'(wIdx), 64'd0);
        checkOutput("t3_b_w0", 64'(wOut), 64'(wExp[1][0]));
        done = 1'b1;
      end else if (seenLast) begin
        checkOutput("t3_bubble_ready", 64'(blkReady), 64'd1);
        gap++;
      end else begin
        checkOutput("t3_early_idle", 64'(wValid), 64'd1);
      end
      if (!done) @(negedge clock);
    end
    blkValid = 1'b0;
    checkOutput("t3_b_started", 64'(done), 64'd1);
    checkOutput("t3_gap", 64'(gap), 64'(expGap));
    for (int t = 0; t < 64; t++) begin
      checkOutput($sformatf("t3_b_idx%0d", t), 64'(wIdx), 64'(t));
      checkOutput($sformatf("t3_b_w%0d", t), 64'(wOut), 64'(wExp[1][t]));
      @(negedge clock);
    end
    checkOutput("t3_idle_valid", 64'(wValid), 64'd0);

    // Test 4: reset in the middle of a block
    applyStimulus(1'b0, blkA, 1'b1);
    loadBlock(blkA, ok);
    checkOutput("t4_load", 64'(ok), 64'd1);
    for (int c = 0; c < 100 && wIdx != 6'd30; c++) @(negedge clock);
    checkOutput("t4_at30", 64'(wIdx), 64'd30);
    checkOutput("t4_w30", 64'(wOut), 64'(wExp[0][30]));
    reset = 1'b1;
    #1 checkOutput("t4_rst_ready", 64'(blkReady), 64'd0);
    @(negedge clock);
    checkOutput("t4_valid", 64'(wValid), 64'd0);
    checkOutput("t4_out", 64'(wOut), 64'd0);
    checkOutput("t4_idx", 64'(wIdx), 64'd0);
    checkOutput("t4_last", 64'(wLast), 64'd0);
    reset = 1'b0;
    loadBlock(blkB, ok);
    checkOutput("t4_reload", 64'(ok), 64'd1);
    checkOutput("t4_reload_valid", 64'(wValid), 64'd1);
    checkOutput("t4_reload_idx", 64'(wIdx), 64'd0);
    checkOutput("t4_reload_w0", 64'(wOut), 64'(wExp[1][0]));
    for (int c = 0; c < 80 && wValid; c++) @(negedge clock);
    checkOutput("t4_drained", 64'(wValid), 64'd0);

    // Test 5: 16-word build streams the block verbatim
    blkValid16 = 1'b1;
    blockIn16  = '1;
    wReady16   = 1'b1;
    #1 checkOutput("t5_ready", 64'(blkReady16), 64'd1);
    @(negedge clock);
    blkValid16 = 1'b0;
    for (int t = 0; t < 16; t++) begin
      checkOutput($sformatf("t5_valid%0d", t), 64'(wValid16), 64'd1);
      checkOutput($sformatf("t5_idx%0d", t), 64'(wIdx16), 64'(t));
      checkOutput($sformatf("t5_w%0d", t), 64'(wOut16), 64'hffffffff);
      checkOutput($sformatf("t5_last%0d", t), 64'(wLast16), 64'(t == 15));
      @(negedge clock);
    end
    checkOutput("t5_idle_valid", 64'(wValid16), 64'd0);
    checkOutput("t5_idle_ready", 64'(blkReady16), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
